seg7_time_decoder: RTL and testbench
====================================

// Module: seg7_time_decoder
// PURPOSE
//   Receive-side counterpart of the stopwatch 7-segment encoder. It samples the four
//   active-low digit buses (sec1, sec2, min1, min2) and filters them for stability.
//   It decodes them back to BCD digits, checks the digits form a legal mm:ss time, and
//   emits total elapsed seconds. Each committed change is classified as step, wrap or jump.
//   Used as the checker/readback path on the display bus (test harness, self-monitor).
// PARAMETERS
//   STABLE_CYCLES  4   consecutive identical samples required before a pattern is committed (>=1)
// PORTS
//   clk        in   1   system clock
//   rst        in   1   asynchronous, active-low reset
//   sec1       in   7   seconds-ones pattern; active-low, bit6=a .. bit0=g
//   sec2       in   7   seconds-tens pattern, same coding
//   min1       in   7   minutes-ones pattern, same coding
//   min2       in   7   minutes-tens pattern, same coding
//   sec_ones   out  4   committed BCD digit
//   sec_tens   out  4   committed BCD digit
//   min_ones   out  4   committed BCD digit
//   min_tens   out  4   committed BCD digit
//   total_sec  out  12  min_tens*600 + min_ones*60 + sec_tens*10 + sec_ones; range 0..3599
//   valid      out  1   high while the outputs hold a legal committed time
//   upd        out  1   1-cycle pulse when a new legal value is committed
//   step       out  1   1-cycle pulse with upd when new total = old total + 1
//   wrap       out  1   1-cycle pulse with upd when old = 3599 and new = 0
//   jump       out  1   1-cycle pulse with upd when valid was already high and neither step nor wrap applies
//   err        out  1   sticky; set on an illegal committed pattern or digit; cleared only by reset
//   err_digit  out  4   sticky mask of offenders {min2,min1,sec2,sec1}; bits OR-accumulate
// BEHAVIOUR
//   - Reset (rst=0, async): all outputs 0, stability counter 0, snapshot 7'b1111111 x4, FSM EMPTY.
//   - Decode table (pattern -> digit):
//     0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4,
//     0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9.
//     Any other pattern is illegal.
//   - Stage 1, sample: the 28-bit concatenation {min2,min1,sec2,sec1} is registered every cycle.
//   - Stage 2, stability filter:
//     * sample != snapshot -> load snapshot, counter = 1.
//     * sample == snapshot -> counter increments, saturating at STABLE_CYCLES.
//     * Commit fires in the single cycle the counter reaches STABLE_CYCLES.
//     * A held pattern never re-commits.
//   - Stage 3, decode/check: on commit, decode the 4 digits. Illegal if any pattern is
//     illegal, or if sec_tens > 5, or if min_tens > 5.
//     * Legal: register the digits and total_sec; raise upd for 1 cycle; raise step/wrap/jump per rules.
//     * Illegal: digits and total_sec hold; set err; OR offending bits into err_digit; no upd.
//   - Latency: first sampling edge of a new stable pattern -> upd/total_sec visible after
//     STABLE_CYCLES+2 edges.
//   - FSM:
//     * EMPTY: valid=0; step/wrap/jump suppressed. Legal commit -> TRACK (upd only).
//     * TRACK: valid=1. Legal commit -> TRACK with classification.
//       Illegal commit -> FAULT: valid=0, last digits held.
//     * FAULT: next legal commit -> TRACK with upd; step/wrap/jump suppressed on that commit.
//   - Arithmetic: total_sec is computed combinationally from 4-bit digits into a 12-bit result.
//     Compare old+1 in 12 bits; 3599+1 is not a step; wrap is checked explicitly.
//   - Simultaneous events: a pattern change in the cycle commit would fire restarts the filter.
//     No commit occurs in that case.
//   - Reset mid-filter or mid-commit: discards everything; returns to EMPTY.
//     The first legal value after reset never pulses step/wrap/jump.
// STRUCTURE
//   - Shared package/header:
//     * The 10 segment pattern constants (SEG_0..SEG_9), shared with the encoder.
//     * The FSM state encodings EMPTY/TRACK/FAULT (2 bits).
//     * MAX_TOTAL = 3599.
//   - One sub-module, seg7_digit_decode: combinational 7-bit pattern -> {legal, digit[3:0]}.
//     Instantiated 4 times.
//   - The top level holds the sample reg, stability filter, FSM, total computation and classification.
// TESTING
//   1. Reset, then drive 00:00 (all 0000001) for 10 cycles
//      -> upd once at edge 6, valid=1, total_sec=0, step=wrap=jump=0.
//   2. From 00:09, change sec1 to 0000001 and sec2 to 1001111 (00:10), hold
//      -> total_sec=10, upd+step pulse once, no further pulses.
//   3. From 59:59 (0100100,0000100,0100100,0000100), change to 00:00 -> total_sec=0, upd+wrap.
//   4. Glitch: toggle sec1 between 1 and 2 every 2 cycles for 20 cycles, then settle on 2
//      -> no upd during toggling; single upd after settle.
//   5. Drive sec2 = 0100000 (6) -> no upd, err=1, err_digit=4'b0010, valid=0, digits held.
//      Then 00:05 -> valid=1, upd, no step.
//   6. Drive 00:03 -> 12:34 -> upd+jump, total_sec=754.
//      Assert rst mid-filter -> all outputs 0, err cleared.

Source files
------------

// File: rtl/seg7_time_decoder_pkg.sv
// Shared constants for the stopwatch 7-segment display bus: segment patterns,
// time-decoder FSM states, and the largest legal mm:ss total.
package seg7_time_decoder_pkg;

  // Active-low segment patterns, bit6=a .. bit0=g (shared with the encoder)
  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;

  localparam logic [11:0] MAX_TOTAL = 12'd3599;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  // mm:ss digits -> elapsed seconds; every digit is widened to 12 bits first
  function automatic logic [11:0] digits_to_total(input logic [3:0] mt, input logic [3:0] mo,
                                                  input logic [3:0] st, input logic [3:0] so);
    return 12'(mt) * 12'd600 + 12'(mo) * 12'd60 + 12'(st) * 12'd10 + 12'(so);
  endfunction

endpackage

// File: rtl/seg7_digit_decode.sv
// Combinational decode of one active-low 7-segment pattern to a BCD digit.
// Patterns outside the ten legal glyphs report legal=0 and digit=0.
module seg7_digit_decode
  import seg7_time_decoder_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       legal,
  output logic [3:0] digit
);

  // Table lookup from glyph to digit
  always_comb begin
    legal = 1'b1;
    digit = 4'd0;
    case (pattern)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_time_decoder.sv
// Readback of the stopwatch display bus: sample, stability filter, decode,
// legality check, elapsed-seconds total and step/wrap/jump classification.
// Handshake: none; upd/step/wrap/jump are single-cycle pulses, valid is a level.
module seg7_time_decoder
  import seg7_time_decoder_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  sec1,
  input  logic [6:0]  sec2,
  input  logic [6:0]  min1,
  input  logic [6:0]  min2,
  output logic [3:0]  sec_ones,
  output logic [3:0]  sec_tens,
  output logic [3:0]  min_ones,
  output logic [3:0]  min_tens,
  output logic [11:0] total_sec,
  output logic        valid,
  output logic        upd,
  output logic        step,
  output logic        wrap,
  output logic        jump,
  output logic        err,
  output logic [3:0]  err_digit,
  output state_t      state_dbg
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_PRE = CW'(STABLE_CYCLES - 1);

  logic [27:0]   sample_q;
  logic [27:0]   snap_q;
  logic [CW-1:0] cnt_q;
  logic          commit_q;
  logic          commit_c;
  state_t        state_q, state_d;

  logic [3:0] dig [4];
  logic [3:0] lgl;
  logic [3:0] bad;
  logic       legal_all;
  logic [11:0] new_total;
  logic upd_d, step_d, wrap_d, jump_d, load_d, err_d;
  logic [3:0] err_digit_d;

  // The change check wins over the count, so a change on the would-be commit cycle restarts
  assign commit_c = (sample_q != snap_q) ? (STABLE_CYCLES == 1) : (cnt_q == CNT_PRE);

  // Sample register, stability filter and registered commit strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_q <= '1;
      snap_q   <= '1;
      cnt_q    <= '0;
      commit_q <= 1'b0;
    end else begin
      sample_q <= {min2, min1, sec2, sec1};
      commit_q <= commit_c;
      if (sample_q != snap_q) begin
        snap_q <= sample_q;
        cnt_q  <= CW'(1);
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  // Four digit decoders on the committed snapshot, index 0 = sec1 .. 3 = min2
  for (genvar g = 0; g < 4; g++) begin : g_dec
    seg7_digit_decode u_dec (
      .pattern (snap_q[7*g +: 7]),
      .legal   (lgl[g]),
      .digit   (dig[g])
    );
  end

  // Offender mask: illegal glyph, or a tens digit above 5
  always_comb begin
    bad       = ~lgl;
    bad[1]    = bad[1] | (dig[1] > 4'd5);
    bad[3]    = bad[3] | (dig[3] > 4'd5);
    legal_all = (bad == 4'b0000);
    new_total = digits_to_total(dig[3], dig[2], dig[1], dig[0]);
  end

  // FSM next state, pulse generation and classification against the previous total
  always_comb begin
    state_d     = state_q;
    upd_d       = 1'b0;
    step_d      = 1'b0;
    wrap_d      = 1'b0;
    jump_d      = 1'b0;
    load_d      = 1'b0;
    err_d       = err;
    err_digit_d = err_digit;
    if (commit_q) begin
      if (legal_all) begin
        load_d  = 1'b1;
        upd_d   = 1'b1;
        state_d = TRACK;
        if (state_q == TRACK) begin
          step_d = (new_total == total_sec + 12'd1);
          wrap_d = (total_sec == MAX_TOTAL) && (new_total == 12'd0);
          jump_d = !step_d && !wrap_d;
        end
      end else begin
        err_d       = 1'b1;
        err_digit_d = err_digit | bad;
        if (state_q == TRACK) state_d = FAULT;
      end
    end
  end

  // State, committed digits/total, pulses and sticky error flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= EMPTY;
      sec_ones  <= '0;
      sec_tens  <= '0;
      min_ones  <= '0;
      min_tens  <= '0;
      total_sec <= '0;
      upd       <= 1'b0;
      step      <= 1'b0;
      wrap      <= 1'b0;
      jump      <= 1'b0;
      err       <= 1'b0;
      err_digit <= '0;
    end else begin
      state_q   <= state_d;
      upd       <= upd_d;
      step      <= step_d;
      wrap      <= wrap_d;
      jump      <= jump_d;
      err       <= err_d;
      err_digit <= err_digit_d;
      if (load_d) begin
        sec_ones  <= dig[0];
        sec_tens  <= dig[1];
        min_ones  <= dig[2];
        min_tens  <= dig[3];
        total_sec <= new_total;
      end
    end
  end

  assign valid     = (state_q == TRACK);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_seg7_time_decoder.sv
// Directed bench for seg7_time_decoder: inputs change 1 time unit after a
// rising edge and outputs are sampled at that same point, away from the edge.
module tb_seg7_time_decoder;
  import seg7_time_decoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  sec1 = '1, sec2 = '1, min1 = '1, min2 = '1;
  logic [3:0]  sec_ones, sec_tens, min_ones, min_tens;
  logic [11:0] total_sec;
  logic        valid, upd, step, wrap, jump, err;
  logic [3:0]  err_digit;
  state_t      state_dbg;

  int n_cmp = 0;
  int n_fail = 0;

  seg7_time_decoder #(.STABLE_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .sec1(sec1), .sec2(sec2), .min1(min1), .min2(min2),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
    .total_sec(total_sec), .valid(valid), .upd(upd), .step(step), .wrap(wrap), .jump(jump),
    .err(err), .err_digit(err_digit), .state_dbg(state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Bench-side glyph table
  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  // Driver: set mm:ss on the four buses
  task automatic drive(input int mt, input int mo, input int st, input int so);
    min2 = seg_of(mt);
    min1 = seg_of(mo);
    sec2 = seg_of(st);
    sec1 = seg_of(so);
  endtask

  // Advance n cycles, landing 1 unit after each edge, counting pulses seen
  task automatic run(input int n, output int nu, output int ns, output int nw, output int nj);
    nu = 0; ns = 0; nw = 0; nj = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      nu += int'(upd); ns += int'(step); nw += int'(wrap); nj += int'(jump);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(15, 15, 15, 15);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({upd, step, wrap, jump, valid, err, err_digit, total_sec} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got upd%b step%b wrap%b jump%b valid%b err%b ed%b tot%0d want all 0",
               upd, step, wrap, jump, valid, err, err_digit, total_sec);
    end
    n_cmp++;
    if (state_dbg !== EMPTY) begin
      n_fail++; $display("FAIL reset_state: got %0d want %0d", state_dbg, EMPTY);
    end
  endtask

  task automatic test_first_commit();
    int nu, ns, nw, nj;
    nu = 0; ns = 0; nw = 0; nj = 0;
    rst = 1'b1;
    drive(0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (upd !== (i == 6)) begin
        n_fail++; $display("FAIL first_upd_edge%0d: got %b want %b", i, upd, (i == 6));
      end
      ns += int'(step); nw += int'(wrap); nj += int'(jump);
    end
    n_cmp++;
    if ({valid, total_sec} !== {1'b1, 12'd0}) begin
      n_fail++; $display("FAIL first_value: got valid %b total %0d want valid 1 total 0", valid, total_sec);
    end
    n_cmp++;
    if (ns + nw + nj != 0) begin
      n_fail++; $display("FAIL first_class: got step %0d wrap %0d jump %0d want 0 0 0", ns, nw, nj);
    end
  endtask

  task automatic test_step();
    int nu, ns, nw, nj;
    drive(0, 0, 0, 9);
    run(10, nu, ns, nw, nj);
    n_cmp++;
    if (total_sec !== 12'd9) begin
      n_fail++; $display("FAIL step_pre_total: got %0d want 9", total_sec);
    end
    drive(0, 0, 1, 0);
    run(12, nu, ns, nw, nj);
    n_cmp++;
    if (total_sec !== 12'd10) begin
      n_fail++; $display("FAIL step_total: got %0d want 10", total_sec);
    end
    n_cmp++;
    if (nu != 1 || ns != 1 || nw != 0 || nj != 0) begin
      n_fail++; $display("FAIL step_pulses: got upd %0d step %0d wrap %0d jump %0d want 1 1 0 0", nu, ns, nw, nj);
    end
  endtask

  task automatic test_wrap();
    int nu, ns, nw, nj;
    drive(5, 9, 5, 9);
    run(10, nu, ns, nw, nj);
    n_cmp++;
    if (total_sec !== 12'd3599 || nj != 1) begin
      n_fail++; $display("FAIL wrap_pre: got total %0d jump %0d want 3599 1", total_sec, nj);
    end
    drive(0, 0, 0, 0);
    run(12, nu, ns, nw, nj);
    n_cmp++;
    if (total_sec !== 12'd0) begin
      n_fail++; $display("FAIL wrap_total: got %0d want 0", total_sec);
    end
    n_cmp++;
    if (nu != 1 || ns != 0 || nw != 1 || nj != 0) begin
      n_fail++; $display("FAIL wrap_pulses: got upd %0d step %0d wrap %0d jump %0d want 1 0 1 0", nu, ns, nw, nj);
    end
  endtask

  task automatic test_glitch();
    int nu, ns, nw, nj, tu;
    tu = 0;
    for (int k = 0; k < 10; k++) begin
      drive(0, 0, 0, (k % 2 == 0) ? 1 : 2);
      run(2, nu, ns, nw, nj);
      tu += nu;
    end
    n_cmp++;
    if (tu != 0) begin
      n_fail++; $display("FAIL glitch_no_upd: got %0d upd pulses want 0", tu);
    end
    drive(0, 0, 0, 2);
    run(10, nu, ns, nw, nj);
    n_cmp++;
    if (nu != 1 || total_sec !== 12'd2 || nj != 1) begin
      n_fail++; $display("FAIL glitch_settle: got upd %0d total %0d jump %0d want 1 2 1", nu, total_sec, nj);
    end
  endtask

  task automatic test_fault();
    int nu, ns, nw, nj;
    min2 = seg_of(0); min1 = seg_of(0); sec2 = 7'b0100000; sec1 = seg_of(2);
    run(10, nu, ns, nw, nj);
    n_cmp++;
    if (nu != 0 || err !== 1'b1 || valid !== 1'b0) begin
      n_fail++; $display("FAIL fault_flags: got upd %0d err %b valid %b want 0 1 0", nu, err, valid);
    end
    n_cmp++;
    if (err_digit !== 4'b0010) begin
      n_fail++; $display("FAIL fault_mask: got %b want 0010", err_digit);
    end
    n_cmp++;
    if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0002 || total_sec !== 12'd2) begin
      n_fail++; $display("FAIL fault_hold: got %h%h:%h%h total %0d want 00:02 total 2",
                         min_tens, min_ones, sec_tens, sec_ones, total_sec);
    end
    drive(0, 0, 0, 5);
    run(10, nu, ns, nw, nj);
    n_cmp++;
    if (valid !== 1'b1 || nu != 1 || ns + nw + nj != 0 || total_sec !== 12'd5) begin
      n_fail++; $display("FAIL fault_recover: got valid %b upd %0d cls %0d total %0d want 1 1 0 5",
                         valid, nu, ns + nw + nj, total_sec);
    end
    n_cmp++;
    if (err !== 1'b1 || err_digit !== 4'b0010) begin
      n_fail++; $display("FAIL fault_sticky: got err %b mask %b want 1 0010", err, err_digit);
    end
  endtask

  task automatic test_jump_and_reset();
    int nu, ns, nw, nj;
    drive(0, 0, 0, 3);
    run(10, nu, ns, nw, nj);
    drive(1, 2, 3, 4);
    run(10, nu, ns, nw, nj);
    n_cmp++;
    if (nu != 1 || nj != 1 || ns != 0 || nw != 0 || total_sec !== 12'd754) begin
      n_fail++; $display("FAIL jump: got upd %0d jump %0d step %0d wrap %0d total %0d want 1 1 0 0 754",
                         nu, nj, ns, nw, total_sec);
    end
    n_cmp++;
    if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h1234) begin
      n_fail++; $display("FAIL jump_digits: got %h want 1234", {min_tens, min_ones, sec_tens, sec_ones});
    end
    drive(0, 0, 0, 0);
    run(3, nu, ns, nw, nj);
    rst = 1'b0;
    #2;
    n_cmp++;
    if ({upd, step, wrap, jump, valid, err, err_digit, total_sec,
         min_tens, min_ones, sec_tens, sec_ones} !== 38'd0 || state_dbg !== EMPTY) begin
      n_fail++; $display("FAIL midreset: got valid %b err %b mask %b total %0d state %0d want all 0",
                         valid, err, err_digit, total_sec, state_dbg);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    run(10, nu, ns, nw, nj);
    n_cmp++;
    if (nu != 1 || ns + nw + nj != 0 || valid !== 1'b1 || total_sec !== 12'd0) begin
      n_fail++; $display("FAIL after_reset: got upd %0d cls %0d valid %b total %0d want 1 0 1 0",
                         nu, ns + nw + nj, valid, total_sec);
    end
  endtask

  initial begin
    test_reset();
    test_first_commit();
    test_step();
    test_wrap();
    test_glitch();
    test_fault();
    test_jump_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got no completion want completion");
    $fatal(1, "timeout");
  end

endmodule
